// File: rtl/intr_source_if.sv
// Register-access and interrupt signal bundle between the core's memory stage and
// the interrupt source block.
interface intr_source_if #(
    parameter int N_EXT = 4
);
    logic [2:0]       addr;
    logic             wr_en;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic [N_EXT-1:0] ext_src;
    logic [3:0]       interrupt;

    modport master (
        output addr,
        output wr_en,
        output wdata,
        output ext_src,
        input  rdata,
        input  interrupt
    );

    modport slave (
        input  addr,
        input  wr_en,
        input  wdata,
        input  ext_src,
        output rdata,
        output interrupt
    );
endinterface

// File: rtl/intr_source_ctrl.sv
// Interrupt source block: prescaled machine timer with compare, edge-latched external
// lines with enable mask, and a software interrupt bit, presented as a 4-bit level vector.
module intr_source_ctrl #(
    parameter int PRESCALE = 1,
    parameter int N_EXT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    intr_source_if.slave bus
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [2:0] A_MTIME    = 3'd0;
    localparam logic [2:0] A_MTIMECMP = 3'd1;
    localparam logic [2:0] A_EXT_PEND = 3'd2;
    localparam logic [2:0] A_EXT_EN   = 3'd3;
    localparam logic [2:0] A_MSIP     = 3'd4;
    localparam logic [2:0] A_STATUS   = 3'd5;

    logic [31:0]      r_mtime;
    logic [31:0]      r_mtimecmp;
    logic [N_EXT-1:0] r_ext_pend;
    logic [N_EXT-1:0] r_ext_en;
    logic             r_msip;
    logic [PS_W-1:0]  r_ps_cnt;
    logic [N_EXT-1:0] r_sync1;
    logic [N_EXT-1:0] r_sync2;
    logic [N_EXT-1:0] r_prev;
    logic [3:0]       r_interrupt;

    logic             w_tick;
    logic [N_EXT-1:0] w_rise;
    logic [N_EXT-1:0] w_w1c;
    logic             w_wr_mtime;
    logic             w_wr_mtimecmp;
    logic             w_wr_pend;
    logic             w_wr_en;
    logic             w_wr_msip;

    assign w_tick        = (r_ps_cnt == PS_W'(PRESCALE - 1));
    assign w_rise        = r_sync2 & ~r_prev;
    assign w_wr_mtime    = bus.wr_en && (bus.addr == A_MTIME);
    assign w_wr_mtimecmp = bus.wr_en && (bus.addr == A_MTIMECMP);
    assign w_wr_pend     = bus.wr_en && (bus.addr == A_EXT_PEND);
    assign w_wr_en       = bus.wr_en && (bus.addr == A_EXT_EN);
    assign w_wr_msip     = bus.wr_en && (bus.addr == A_MSIP);
    assign w_w1c         = w_wr_pend ? bus.wdata[N_EXT-1:0] : '0;

    // Timer: a software load of MTIME restarts the prescale period and beats a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime    <= '0;
            r_mtimecmp <= 32'hFFFF_FFFF;
            r_ps_cnt   <= '0;
        end else begin
            if (w_wr_mtime) begin
                r_mtime  <= bus.wdata;
                r_ps_cnt <= '0;
            end else begin
                if (w_tick) begin
                    r_mtime <= r_mtime + 32'd1;
                end
                r_ps_cnt <= w_tick ? '0 : r_ps_cnt + PS_W'(1);
            end
            if (w_wr_mtimecmp) begin
                r_mtimecmp <= bus.wdata;
            end
        end
    end

    // External lines: a fresh rise overrides a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= '0;
            r_ext_pend <= '0;
            r_ext_en   <= '0;
            r_msip     <= 1'b0;
        end else begin
            r_sync1    <= bus.ext_src;
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            r_ext_pend <= (r_ext_pend & ~w_w1c) | w_rise;
            if (w_wr_en) begin
                r_ext_en <= bus.wdata[N_EXT-1:0];
            end
            if (w_wr_msip) begin
                r_msip <= bus.wdata[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_interrupt <= 4'b0000;
        end else begin
            r_interrupt[0] <= (r_mtime >= r_mtimecmp);
            r_interrupt[1] <= |(r_ext_pend & r_ext_en);
            r_interrupt[2] <= r_msip;
            r_interrupt[3] <= 1'b0;
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            A_MTIME:    bus.rdata = r_mtime;
            A_MTIMECMP: bus.rdata = r_mtimecmp;
            A_EXT_PEND: bus.rdata = {{(32 - N_EXT){1'b0}}, r_ext_pend};
            A_EXT_EN:   bus.rdata = {{(32 - N_EXT){1'b0}}, r_ext_en};
            A_MSIP:     bus.rdata = {31'd0, r_msip};
            A_STATUS:   bus.rdata = {28'd0, r_interrupt};
            default:    bus.rdata = 32'd0;
        endcase
    end

    assign bus.interrupt = r_interrupt;
endmodule

// File: tb/tb_intr_source_ctrl.sv
// Directed bench for intr_source_ctrl: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_intr_source_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    intr_source_if #(.N_EXT(4)) bus1 ();
    intr_source_if #(.N_EXT(4)) bus4 ();

    intr_source_ctrl #(.PRESCALE(1), .N_EXT(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    intr_source_ctrl #(.PRESCALE(4), .N_EXT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus helpers: called in the negedge phase; a write lands on the following posedge.
    task automatic wr1(input logic [2:0] a, input logic [31:0] d);
        bus1.addr = a; bus1.wdata = d; bus1.wr_en = 1'b1;
        @(negedge clk);
        bus1.wr_en = 1'b0;
    endtask

    task automatic wr4(input logic [2:0] a, input logic [31:0] d);
        bus4.addr = a; bus4.wdata = d; bus4.wr_en = 1'b1;
        @(negedge clk);
        bus4.wr_en = 1'b0;
    endtask

    task automatic rd1(input logic [2:0] a, output logic [31:0] d);
        bus1.addr = a;
        #1;
        d = bus1.rdata;
    endtask

    task automatic rd4(input logic [2:0] a, output logic [31:0] d);
        bus4.addr = a;
        #1;
        d = bus4.rdata;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst = 1'b1;
        cycles(2);
        n_checks++;
        if (bus1.interrupt !== 4'b0000) begin
            n_errors++; $display("FAIL reset_irq: got %b expected 0000", bus1.interrupt);
        end
        rst = 1'b0;
        cycles(10);
        n_checks++;
        if (bus1.interrupt !== 4'b0000) begin
            n_errors++; $display("FAIL idle_irq: got %b expected 0000", bus1.interrupt);
        end
        rd1(3'd0, v);
        n_checks++;
        if (v !== 32'd10) begin
            n_errors++; $display("FAIL idle_mtime: got %0d expected 10", v);
        end
        rd1(3'd1, v);
        n_checks++;
        if (v !== 32'hFFFF_FFFF) begin
            n_errors++; $display("FAIL reset_mtimecmp: got %h expected ffffffff", v);
        end
        rd4(3'd0, v);
        n_checks++;
        if (v !== 32'd2) begin
            n_errors++; $display("FAIL idle_mtime_ps4: got %0d expected 2", v);
        end
    endtask

    task automatic test_timer_compare;
        logic [31:0] v;
        bit          found;
        wr1(3'd0, 32'd0);
        wr1(3'd1, 32'd20);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            rd1(3'd0, v);
            if (v == 32'd20) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_errors++; $display("FAIL cmp_reach: got %0d expected 20 within 40 cycles", v);
        end
        n_checks++;
        if (bus1.interrupt[0] !== 1'b0) begin
            n_errors++; $display("FAIL cmp_at_20: got %b expected 0", bus1.interrupt[0]);
        end
        @(negedge clk);
        n_checks++;
        if (bus1.interrupt[0] !== 1'b1) begin
            n_errors++; $display("FAIL cmp_fire: got %b expected 1", bus1.interrupt[0]);
        end
        wr1(3'd1, 32'hFFFF_FFFF);
        n_checks++;
        if (bus1.interrupt[0] !== 1'b1) begin
            n_errors++; $display("FAIL cmp_hold: got %b expected 1", bus1.interrupt[0]);
        end
        @(negedge clk);
        n_checks++;
        if (bus1.interrupt[0] !== 1'b0) begin
            n_errors++; $display("FAIL cmp_clear: got %b expected 0", bus1.interrupt[0]);
        end
    endtask

    task automatic test_prescale;
        logic [31:0] v;
        wr4(3'd0, 32'hFFFF_FFFE);
        cycles(3);
        rd4(3'd0, v);
        n_checks++;
        if (v !== 32'hFFFF_FFFE) begin
            n_errors++; $display("FAIL ps_hold3: got %h expected fffffffe", v);
        end
        @(negedge clk);
        rd4(3'd0, v);
        n_checks++;
        if (v !== 32'hFFFF_FFFF) begin
            n_errors++; $display("FAIL ps_step4: got %h expected ffffffff", v);
        end
        cycles(3);
        rd4(3'd0, v);
        n_checks++;
        if (v !== 32'hFFFF_FFFF) begin
            n_errors++; $display("FAIL ps_hold7: got %h expected ffffffff", v);
        end
        @(negedge clk);
        rd4(3'd0, v);
        n_checks++;
        if (v !== 32'd0) begin
            n_errors++; $display("FAIL ps_wrap: got %h expected 00000000", v);
        end
        cycles(3);
        wr4(3'd0, 32'h100);
        rd4(3'd0, v);
        n_checks++;
        if (v !== 32'h100) begin
            n_errors++; $display("FAIL ps_wr_wins: got %h expected 00000100", v);
        end
        cycles(3);
        rd4(3'd0, v);
        n_checks++;
        if (v !== 32'h100) begin
            n_errors++; $display("FAIL ps_restart: got %h expected 00000100", v);
        end
        @(negedge clk);
        rd4(3'd0, v);
        n_checks++;
        if (v !== 32'h101) begin
            n_errors++; $display("FAIL ps_after_wr: got %h expected 00000101", v);
        end
    endtask

    task automatic test_ext_edge;
        logic [31:0] v;
        wr1(3'd3, 32'b0010);
        bus1.ext_src = 4'b0010;
        @(negedge clk);
        bus1.ext_src = 4'b0000;
        cycles(2);
        rd1(3'd2, v);
        n_checks++;
        if (v !== 32'b0010 || bus1.interrupt[1] !== 1'b0) begin
            n_errors++; $display("FAIL ext_edge3: got pend=%h irq1=%b expected pend=2 irq1=0", v, bus1.interrupt[1]);
        end
        @(negedge clk);
        n_checks++;
        if (bus1.interrupt[1] !== 1'b1) begin
            n_errors++; $display("FAIL ext_edge4: got %b expected 1", bus1.interrupt[1]);
        end
        wr1(3'd2, 32'b0010);
        rd1(3'd2, v);
        n_checks++;
        if (v !== 32'd0) begin
            n_errors++; $display("FAIL ext_w1c: got %h expected 0", v);
        end
        @(negedge clk);
        n_checks++;
        if (bus1.interrupt[1] !== 1'b0) begin
            n_errors++; $display("FAIL ext_irq_clear: got %b expected 0", bus1.interrupt[1]);
        end
        bus1.ext_src = 4'b0010;
        cycles(5);
        rd1(3'd2, v);
        n_checks++;
        if (v !== 32'b0010) begin
            n_errors++; $display("FAIL ext_level_set: got %h expected 2", v);
        end
        wr1(3'd2, 32'b0010);
        cycles(5);
        rd1(3'd2, v);
        n_checks++;
        if (v !== 32'd0 || bus1.interrupt[1] !== 1'b0) begin
            n_errors++; $display("FAIL ext_level_no_reset: got pend=%h irq1=%b expected pend=0 irq1=0", v, bus1.interrupt[1]);
        end
        bus1.ext_src = 4'b0000;
        cycles(3);
    endtask

    task automatic test_ext_mask;
        logic [31:0] v;
        wr1(3'd3, 32'd0);
        bus1.ext_src = 4'b0001;
        @(negedge clk);
        bus1.ext_src = 4'b0000;
        cycles(3);
        rd1(3'd2, v);
        n_checks++;
        if (v !== 32'b0001 || bus1.interrupt[1] !== 1'b0) begin
            n_errors++; $display("FAIL ext_masked: got pend=%h irq1=%b expected pend=1 irq1=0", v, bus1.interrupt[1]);
        end
        wr1(3'd3, 32'b0001);
        @(negedge clk);
        n_checks++;
        if (bus1.interrupt[1] !== 1'b1) begin
            n_errors++; $display("FAIL ext_unmask: got %b expected 1", bus1.interrupt[1]);
        end
        bus1.ext_src = 4'b0001;
        @(negedge clk);
        bus1.ext_src = 4'b0000;
        @(negedge clk);
        wr1(3'd2, 32'b0001);
        rd1(3'd2, v);
        n_checks++;
        if (v !== 32'b0001) begin
            n_errors++; $display("FAIL ext_rise_beats_w1c: got %h expected 1", v);
        end
        wr1(3'd2, 32'b0001);
        rd1(3'd2, v);
        n_checks++;
        if (v !== 32'd0) begin
            n_errors++; $display("FAIL ext_w1c_bit0: got %h expected 0", v);
        end
    endtask

    task automatic test_msip_and_map;
        logic [31:0] v;
        wr1(3'd4, 32'hFFFF_FFFF);
        rd1(3'd4, v);
        n_checks++;
        if (v !== 32'd1) begin
            n_errors++; $display("FAIL msip_read: got %h expected 1", v);
        end
        @(negedge clk);
        n_checks++;
        if (bus1.interrupt !== 4'b0100) begin
            n_errors++; $display("FAIL msip_irq: got %b expected 0100", bus1.interrupt);
        end
        rd1(3'd5, v);
        n_checks++;
        if (v !== 32'h4) begin
            n_errors++; $display("FAIL status_read: got %h expected 4", v);
        end
        wr1(3'd7, 32'hDEAD_BEEF);
        rd1(3'd6, v);
        n_checks++;
        if (v !== 32'd0) begin
            n_errors++; $display("FAIL addr6_read: got %h expected 0", v);
        end
        rd1(3'd7, v);
        n_checks++;
        if (v !== 32'd0) begin
            n_errors++; $display("FAIL addr7_read: got %h expected 0", v);
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] v;
        wr1(3'd3, 32'b0101);
        wr1(3'd0, 32'h55);
        rd1(3'd0, v);
        n_checks++;
        if (v !== 32'h55 || bus1.interrupt[2] !== 1'b1) begin
            n_errors++; $display("FAIL pre_reset: got mtime=%h irq2=%b expected 55 and 1", v, bus1.interrupt[2]);
        end
        rst = 1'b1;
        rd1(3'd0, v);
        n_checks++;
        if (v !== 32'd0) begin
            n_errors++; $display("FAIL async_mtime: got %h expected 0", v);
        end
        rd1(3'd1, v);
        n_checks++;
        if (v !== 32'hFFFF_FFFF) begin
            n_errors++; $display("FAIL async_mtimecmp: got %h expected ffffffff", v);
        end
        rd1(3'd3, v);
        n_checks++;
        if (v !== 32'd0) begin
            n_errors++; $display("FAIL async_ext_en: got %h expected 0", v);
        end
        rd1(3'd4, v);
        n_checks++;
        if (v !== 32'd0 || bus1.interrupt !== 4'b0000) begin
            n_errors++; $display("FAIL async_msip_irq: got msip=%h irq=%b expected 0 and 0000", v, bus1.interrupt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus1.addr = 3'd0; bus1.wr_en = 1'b0; bus1.wdata = 32'd0; bus1.ext_src = 4'b0000;
        bus4.addr = 3'd0; bus4.wr_en = 1'b0; bus4.wdata = 32'd0; bus4.ext_src = 4'b0000;
        @(negedge clk);
        test_reset();
        test_timer_compare();
        test_prescale();
        test_ext_edge();
        test_ext_mask();
        test_msip_and_map();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/intr_source_ctrl.md
Name: intr_source_ctrl

Overview:
Memory-mapped interrupt source block that drives the core's 4-bit `interrupt` input, making it the producer end of the interrupt interface the core's CSR unit consumes.
- Contains a prescaled machine timer with compare register, edge-latched external interrupt lines with enable mask, and a software interrupt bit.
- Sits beside data memory in the writeback/memory stage address space; the core reads and acknowledges it through plain load/store accesses.

Parameters:
PRESCALE, 1, number of clk cycles per MTIME increment (legal range ≥1)
N_EXT, 4, number of external interrupt source lines

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
addr  input  3  word offset of register access
wr_en  input  1  write strobe, single-cycle, sampled at rising clk
wdata  input  32  write data
rdata  output  32  combinational read data for addr
ext_src  input  N_EXT  asynchronous external interrupt request lines
interrupt  output  4  registered interrupt vector to core: [0] timer, [1] external, [2] software, [3] reserved

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- rst forces immediately, including mid-operation:
  - MTIME=0, MTIMECMP=0xFFFF_FFFF, EXT_PEND=0, EXT_EN=0, MSIP=0.
  - Prescaler count=0, sync/edge flops=0, interrupt=4'b0000.
- Register map (word offsets), all 32-bit:
  - 0 MTIME: RW.
  - 1 MTIMECMP: RW.
  - 2 EXT_PEND: RO bits, write-1-to-clear, bits above N_EXT read 0.
  - 3 EXT_EN: RW, low N_EXT bits.
  - 4 MSIP: RW bit0 only.
  - 5 STATUS: RO, {28'b0, interrupt}.
  - 6–7: read 0, writes ignored.
- Prescaler: counts 0..PRESCALE-1 and emits a tick in the cycle it equals PRESCALE-1, then wraps to 0. On a tick, MTIME increments by 1 modulo 2^32; 0xFFFF_FFFF wraps to 0 with no flag. PRESCALE=1 means tick every cycle.
- MTIME write: loads wdata and clears the prescaler. The write wins over a same-cycle tick.
- External path, per line:
  - 2-flop synchronizer, then a previous-value flop; rise = sync2 & ~prev.
  - A rise sets the EXT_PEND bit.
  - A W1C write clears the bit; a same-cycle rise wins and the bit stays 1.
  - Level-held lines do not re-set the bit after it is cleared.
- interrupt is registered, one cycle after its source condition:
  - interrupt[0] <= (MTIME >= MTIMECMP), unsigned, using current register values.
  - interrupt[1] <= |(EXT_PEND & EXT_EN).
  - interrupt[2] <= MSIP[0].
  - interrupt[3] <= 0.
- Interrupts are level, not pulses. A bit stays asserted until software clears the cause: write MTIMECMP greater than MTIME, W1C the EXT_PEND bit or clear its enable, or write MSIP=0.
- Latency, ext_src rise to interrupt[1] (set-up met, line enabled):
  - Edge 1: sync1. Edge 2: sync2. Edge 3: pending set. Edge 4: interrupt[1]=1.
- rdata: purely combinational from addr and current register state. A read in the same cycle as a write returns the old value.

Test Plan:
- Reset, then idle 10 cycles (PRESCALE=1) -> interrupt=0000, MTIME reads 10 ±1 per sample point, MTIMECMP reads 0xFFFF_FFFF.
- Write MTIMECMP=20 with PRESCALE=1 from MTIME=0 -> interrupt[0] first high one cycle after MTIME reaches 20. Write MTIMECMP=0xFFFF_FFFF -> interrupt[0] low next cycle.
- PRESCALE=4: write MTIME=0xFFFF_FFFE, wait 8 cycles -> MTIME=0, exactly 4 cycles between increments. Write MTIME with a tick in the same cycle -> written value held, no increment.
- EXT_EN=0b0010, pulse ext_src[1] high for 1 cycle -> EXT_PEND=0b0010, interrupt[1]=1 on edge 4. W1C 0b0010 -> interrupt[1]=0 next cycle. ext_src[1] held high -> no re-set.
- Pulse ext_src[0] with EXT_EN=0 -> EXT_PEND bit0=1, interrupt[1]=0. Set EXT_EN bit0 -> interrupt[1]=1 next cycle. Rise coincident with W1C -> bit stays 1.
- Write MSIP=1 -> interrupt[2]=1 next cycle. Assert rst mid-count with MTIME=0x55 -> all registers and interrupt at reset values without a clock edge. Read addr 6 -> rdata=0.
